// File: rtl/alarm_pkg.sv
// Shared widths, limits and FSM state type for the alarm controller slice.
package alarm_pkg;

   localparam int HOUR_W   = 5;
   localparam int MIN_W    = 6;
   localparam int SEC_W    = 6;
   localparam int MAX_HOUR = 23;
   localparam int MAX_MIN  = 59;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_t;

   function automatic logic time_valid(input logic [HOUR_W-1:0] hour,
                                       input logic [MIN_W-1:0]  minute);
      return (hour <= HOUR_W'(MAX_HOUR)) && (minute <= MIN_W'(MAX_MIN));
   endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Time/control inputs and ring/indicator outputs of the alarm controller.
interface alarm_ctrl_if;

   logic [alarm_pkg::HOUR_W-1:0] HOUR;
   logic [alarm_pkg::MIN_W-1:0]  MINUTE;
   logic [alarm_pkg::SEC_W-1:0]  SECOND;
   logic                         SET_EN;
   logic [alarm_pkg::HOUR_W-1:0] SET_HOUR;
   logic [alarm_pkg::MIN_W-1:0]  SET_MINUTE;
   logic                         ALARM_EN;
   logic                         SNOOZE;
   logic                         STOP;
   logic                         RING;
   logic                         SNOOZING;
   logic [alarm_pkg::HOUR_W-1:0] ALARM_HOUR;
   logic [alarm_pkg::MIN_W-1:0]  ALARM_MINUTE;

   modport master (
      output HOUR, MINUTE, SECOND, SET_EN, SET_HOUR, SET_MINUTE, ALARM_EN, SNOOZE, STOP,
      input  RING, SNOOZING, ALARM_HOUR, ALARM_MINUTE
   );

   modport slave (
      input  HOUR, MINUTE, SECOND, SET_EN, SET_HOUR, SET_MINUTE, ALARM_EN, SNOOZE, STOP,
      output RING, SNOOZING, ALARM_HOUR, ALARM_MINUTE
   );

endinterface

// File: rtl/alarm_ctrl_sec_tick_det.sv
// Flags a one-cycle sec_tick whenever SECOND differs from its value last cycle.
// Combinational output, one register of history; reset history is 0.
module sec_tick_det
   import alarm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [SEC_W-1:0] second,
   output logic             sec_tick
);

   logic [SEC_W-1:0] prev_sec_d, prev_sec_q;

   always_comb begin
      prev_sec_d = second;
      sec_tick   = (second != prev_sec_q);
   end

   always_ff @(posedge clk) begin
      if (rst) prev_sec_q <= '0;
      else     prev_sec_q <= prev_sec_d;
   end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm time registers, edge-detected time match and ring/snooze FSM with bounded snoozes.
// All outputs registered: one cycle from trigger, STOP, SNOOZE or timeout to RING/SNOOZING.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int SNOOZE_SEC = 300,
   parameter int RING_SEC   = 60,
   parameter int MAX_SNOOZE = 3
)(
   input  logic       CLK,
   input  logic       RST,
   alarm_ctrl_if.slave bus
);

   localparam int RING_W = (RING_SEC   > 1) ? $clog2(RING_SEC)   : 1;
   localparam int SNZ_W  = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
   localparam int NUM_W  = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

   localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
   localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SEC - 1);
   localparam logic [NUM_W-1:0]  NUM_MAX   = NUM_W'(MAX_SNOOZE);

   logic sec_tick;

   sec_tick_det u_sec_tick_det (
      .clk      (CLK),
      .rst      (RST),
      .second   (bus.SECOND),
      .sec_tick (sec_tick)
   );

   alarm_state_t      state_d, state_q;
   logic [RING_W-1:0] ring_cnt_d, ring_cnt_q;
   logic [SNZ_W-1:0]  snz_cnt_d, snz_cnt_q;
   logic [NUM_W-1:0]  snooze_num_d, snooze_num_q;
   logic [HOUR_W-1:0] alarm_hour_d, alarm_hour_q;
   logic [MIN_W-1:0]  alarm_min_d, alarm_min_q;
   logic              match_d, match_q;
   logic              ring_d, ring_q;
   logic              snoozing_d, snoozing_q;
   logic              trigger, ring_done, snz_done, snooze_ok, leave_active;

   always_comb begin
      match_d = (bus.HOUR == alarm_hour_q) && (bus.MINUTE == alarm_min_q) && (bus.SECOND == '0);
      // Rising edge only, so a held 00 second fires once.
      trigger      = match_d && !match_q;
      ring_done    = sec_tick && (ring_cnt_q == RING_LAST);
      snz_done     = sec_tick && (snz_cnt_q == SNZ_LAST);
      snooze_ok    = bus.SNOOZE && (snooze_num_q < NUM_MAX);
      leave_active = bus.SET_EN || bus.STOP;

      alarm_hour_d = alarm_hour_q;
      alarm_min_d  = alarm_min_q;
      if (bus.SET_EN && time_valid(bus.SET_HOUR, bus.SET_MINUTE)) begin
         alarm_hour_d = bus.SET_HOUR;
         alarm_min_d  = bus.SET_MINUTE;
      end

      state_d      = state_q;
      ring_cnt_d   = ring_cnt_q;
      snz_cnt_d    = snz_cnt_q;
      snooze_num_d = snooze_num_q;

      if (!bus.ALARM_EN) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_d      = RINGING;
                  ring_cnt_d   = '0;
                  snooze_num_d = '0;
               end
            end
            RINGING: begin
               // SNOOZE beats a coincident timeout while snoozes remain.
               if (leave_active) begin
                  state_d = IDLE;
               end else if (snooze_ok) begin
                  state_d      = SNOOZE;
                  snooze_num_d = snooze_num_q + NUM_W'(1);
                  snz_cnt_d    = '0;
               end else if (ring_done) begin
                  state_d = IDLE;
               end else if (sec_tick) begin
                  ring_cnt_d = ring_cnt_q + RING_W'(1);
               end
            end
            SNOOZE: begin
               if (leave_active) begin
                  state_d = IDLE;
               end else if (snz_done) begin
                  state_d    = RINGING;
                  ring_cnt_d = '0;
               end else if (sec_tick) begin
                  snz_cnt_d = snz_cnt_q + SNZ_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      ring_d     = (state_d == RINGING);
      snoozing_d = (state_d == SNOOZE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         ring_cnt_q   <= '0;
         snz_cnt_q    <= '0;
         snooze_num_q <= '0;
         alarm_hour_q <= '0;
         alarm_min_q  <= '0;
         // Starts high so 00:00:00 with a 00:00 alarm is not seen as a new match.
         match_q      <= 1'b1;
         ring_q       <= 1'b0;
         snoozing_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ring_cnt_q   <= ring_cnt_d;
         snz_cnt_q    <= snz_cnt_d;
         snooze_num_q <= snooze_num_d;
         alarm_hour_q <= alarm_hour_d;
         alarm_min_q  <= alarm_min_d;
         match_q      <= match_d;
         ring_q       <= ring_d;
         snoozing_q   <= snoozing_d;
      end
   end

   assign bus.RING         = ring_q;
   assign bus.SNOOZING     = snoozing_q;
   assign bus.ALARM_HOUR   = alarm_hour_q;
   assign bus.ALARM_MINUTE = alarm_min_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed and randomized bench for alarm_ctrl against a countdown-style reference model.
module tb_alarm_ctrl;

   localparam int SNOOZE_SEC = 300;
   localparam int RING_SEC   = 60;
   localparam int MAX_SNOOZE = 3;
   localparam int DAY_SEC    = 86400;

   logic CLK;
   logic RST;

   alarm_ctrl_if bus ();

   alarm_ctrl #(
      .SNOOZE_SEC (SNOOZE_SEC),
      .RING_SEC   (RING_SEC),
      .MAX_SNOOZE (MAX_SNOOZE)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int checks   = 0;
   int failures = 0;

   // Reference model: ringing/snoozing flags with seconds-remaining countdowns.
   bit         m_ring, m_snz;
   int         m_ring_left, m_snz_left, m_used;
   logic [4:0] m_ah;
   logic [5:0] m_am;
   logic [5:0] m_prev_sec;
   bit         m_prev_match;
   int         tod;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_tod(input int t);
      bus.HOUR   = 5'(t / 3600);
      bus.MINUTE = 6'((t / 60) % 60);
      bus.SECOND = 6'(t % 60);
   endtask

   task automatic cyc();
      bit tick, match, trig, n_ring, n_snz, n_pm;
      int n_rl, n_sl, n_used;
      logic [4:0] n_ah;
      logic [5:0] n_am, n_ps;
      n_ring = m_ring; n_snz = m_snz; n_rl = m_ring_left; n_sl = m_snz_left;
      n_used = m_used; n_ah = m_ah; n_am = m_am;
      tick  = (bus.SECOND != m_prev_sec);
      match = (bus.HOUR == m_ah) && (bus.MINUTE == m_am) && (bus.SECOND == 6'd0);
      trig  = match && !m_prev_match;
      n_ps  = bus.SECOND;
      n_pm  = match;
      if (RST) begin
         n_ring = 0; n_snz = 0; n_used = 0; n_ah = '0; n_am = '0; n_ps = '0; n_pm = 1;
      end else begin
         if (bus.SET_EN && bus.SET_HOUR < 24 && bus.SET_MINUTE < 60) begin
            n_ah = bus.SET_HOUR;
            n_am = bus.SET_MINUTE;
         end
         if (!bus.ALARM_EN) begin
            n_ring = 0; n_snz = 0;
         end else if ((m_ring || m_snz) && bus.SET_EN) begin
            n_ring = 0; n_snz = 0;
         end else if (m_ring) begin
            if (bus.STOP) n_ring = 0;
            else if (bus.SNOOZE && m_used < MAX_SNOOZE) begin
               n_ring = 0; n_snz = 1; n_used = m_used + 1; n_sl = SNOOZE_SEC;
            end else if (tick) begin
               n_rl = m_ring_left - 1;
               if (n_rl == 0) n_ring = 0;
            end
         end else if (m_snz) begin
            if (bus.STOP) n_snz = 0;
            else if (tick) begin
               n_sl = m_snz_left - 1;
               if (n_sl == 0) begin n_snz = 0; n_ring = 1; n_rl = RING_SEC; end
            end
         end else if (trig) begin
            n_ring = 1; n_rl = RING_SEC; n_used = 0;
         end
      end
      @(posedge CLK);
      #1;
      m_ring = n_ring; m_snz = n_snz; m_ring_left = n_rl; m_snz_left = n_sl;
      m_used = n_used; m_ah = n_ah; m_am = n_am; m_prev_sec = n_ps; m_prev_match = n_pm;
      chk("ring",         8'(bus.RING),         8'(m_ring));
      chk("snoozing",     8'(bus.SNOOZING),     8'(m_snz));
      chk("alarm_hour",   8'(bus.ALARM_HOUR),   8'(m_ah));
      chk("alarm_minute", 8'(bus.ALARM_MINUTE), 8'(m_am));
   endtask

   task automatic set_alarm(input int h, input int m);
      bus.SET_EN     = 1'b1;
      bus.SET_HOUR   = 5'(h);
      bus.SET_MINUTE = 6'(m);
      cyc();
      bus.SET_EN = 1'b0;
   endtask

   task automatic advance();
      tod = (tod + 1) % DAY_SEC;
      set_tod(tod);
      cyc();
   endtask

   task automatic fire(input int h, input int m);
      tod = (h * 3600 + m * 60 + DAY_SEC - 1) % DAY_SEC;
      set_tod(tod);
      cyc();
      advance();
   endtask

   initial begin
      int cnt_ring, cnt_snz, a_sec;
      m_ring = 0; m_snz = 0; m_ring_left = 0; m_snz_left = 0; m_used = 0;
      m_ah = '0; m_am = '0; m_prev_sec = '0; m_prev_match = 1;
      RST = 1'b1;
      tod = 0;
      set_tod(0);
      bus.SET_EN = 1'b0; bus.SET_HOUR = '0; bus.SET_MINUTE = '0;
      bus.ALARM_EN = 1'b1; bus.SNOOZE = 1'b0; bus.STOP = 1'b0;

      // Reset with time and alarm both at 00:00:00: no trigger afterwards.
      cyc(); cyc();
      chk("reset_ring", 8'(bus.RING), 8'd0);
      chk("reset_snoozing", 8'(bus.SNOOZING), 8'd0);
      chk("reset_alarm_hour", 8'(bus.ALARM_HOUR), 8'd0);
      RST = 1'b0;
      repeat (3) cyc();
      chk("no_trigger_after_reset", 8'(bus.RING), 8'd0);

      // Basic fire at 07:30, held until STOP.
      set_alarm(7, 30);
      chk("set_hour", 8'(bus.ALARM_HOUR), 8'd7);
      chk("set_minute", 8'(bus.ALARM_MINUTE), 8'd30);
      tod = 7 * 3600 + 29 * 60 + 58;
      set_tod(tod); cyc();
      advance();
      chk("before_fire", 8'(bus.RING), 8'd0);
      advance();
      chk("basic_fire", 8'(bus.RING), 8'd1);
      repeat (5) cyc();
      chk("ring_held", 8'(bus.RING), 8'd1);
      bus.STOP = 1'b1; cyc(); bus.STOP = 1'b0;
      chk("stop", 8'(bus.RING), 8'd0);
      cyc();

      // Auto-off after RING_SEC ticks.
      fire(7, 30);
      cnt_ring = int'(bus.RING);
      cnt_snz  = 0;
      for (int i = 0; i < 80; i++) begin
         advance();
         cnt_ring += int'(bus.RING);
         cnt_snz  += int'(bus.SNOOZING);
      end
      chk("autooff_ring_cycles", 8'(cnt_ring), 8'(RING_SEC));
      chk("autooff_no_snooze", 8'(cnt_snz), 8'd0);

      // Snooze cycles, then the extra SNOOZE is ignored.
      fire(7, 30);
      for (int k = 0; k < MAX_SNOOZE; k++) begin
         bus.SNOOZE = 1'b1; cyc(); bus.SNOOZE = 1'b0;
         chk("snooze_enter", 8'(bus.SNOOZING), 8'd1);
         chk("snooze_ring_off", 8'(bus.RING), 8'd0);
         repeat (SNOOZE_SEC - 1) advance();
         chk("snooze_not_yet", 8'(bus.RING), 8'd0);
         advance();
         chk("snooze_rering", 8'(bus.RING), 8'd1);
      end
      bus.SNOOZE = 1'b1; cyc(); bus.SNOOZE = 1'b0;
      chk("snooze_exhausted_ring", 8'(bus.RING), 8'd1);
      chk("snooze_exhausted_snz", 8'(bus.SNOOZING), 8'd0);
      bus.STOP = 1'b1; cyc(); bus.STOP = 1'b0;

      // STOP beats SNOOZE; ALARM_EN low leaves SNOOZE.
      fire(7, 30);
      bus.STOP = 1'b1; bus.SNOOZE = 1'b1; cyc();
      bus.STOP = 1'b0; bus.SNOOZE = 1'b0;
      chk("stop_wins_ring", 8'(bus.RING), 8'd0);
      chk("stop_wins_snz", 8'(bus.SNOOZING), 8'd0);
      fire(7, 30);
      bus.SNOOZE = 1'b1; cyc(); bus.SNOOZE = 1'b0;
      bus.ALARM_EN = 1'b0; cyc();
      chk("disable_in_snooze", 8'(bus.SNOOZING), 8'd0);
      bus.ALARM_EN = 1'b1; cyc();

      // Midnight wrap fires a 00:00 alarm.
      set_alarm(0, 0);
      fire(0, 0);
      chk("midnight_fire", 8'(bus.RING), 8'd1);
      bus.STOP = 1'b1; cyc(); bus.STOP = 1'b0;

      // Reset mid-ring clears RING and the alarm registers.
      set_alarm(5, 15);
      fire(5, 15);
      chk("fire_before_reset", 8'(bus.RING), 8'd1);
      RST = 1'b1; cyc(); RST = 1'b0;
      chk("reset_mid_ring", 8'(bus.RING), 8'd0);
      chk("reset_mid_ring_hour", 8'(bus.ALARM_HOUR), 8'd0);
      cyc();

      // Out-of-range loads keep the previous alarm.
      set_alarm(6, 45);
      set_alarm(24, 10);
      chk("invalid_hour_keep_h", 8'(bus.ALARM_HOUR), 8'd6);
      chk("invalid_hour_keep_m", 8'(bus.ALARM_MINUTE), 8'd45);
      set_alarm(6, 60);
      chk("invalid_min_keep_h", 8'(bus.ALARM_HOUR), 8'd6);
      chk("invalid_min_keep_m", 8'(bus.ALARM_MINUTE), 8'd45);

      // Randomized traffic around the alarm time.
      set_alarm(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
      tod = (int'(m_ah) * 3600 + int'(m_am) * 60 + DAY_SEC - 5) % DAY_SEC;
      for (int i = 0; i < 6000; i++) begin
         RST            = ($urandom_range(0, 1499) == 0);
         bus.SNOOZE     = ($urandom_range(0, 24) == 0);
         bus.STOP       = ($urandom_range(0, 149) == 0);
         bus.ALARM_EN   = ($urandom_range(0, 299) != 0);
         bus.SET_EN     = ($urandom_range(0, 399) == 0);
         bus.SET_HOUR   = 5'($urandom_range(0, 31));
         bus.SET_MINUTE = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 399) == 0) begin
            a_sec = int'(m_ah) * 3600 + int'(m_am) * 60;
            tod = (a_sec + DAY_SEC - 3) % DAY_SEC;
         end else if ($urandom_range(0, 3) != 0) begin
            tod = (tod + 1) % DAY_SEC;
         end
         set_tod(tod);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
